// File: rtl/mips_alu_muldiv.sv
// Clocked MIPS EX-stage ALU: single-cycle logic/arithmetic ops with a registered
// result, plus iterative radix-2 multiply/divide into HI/LO with MFHI/MFLO.
module mips_alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       selectionLines,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALU_result,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t             state_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   result_r;
    logic               zero_r;
    logic               ovf_r;
    logic               dbz_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] prod_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   b_mag_r;
    logic [WIDTH-1:0]   a_raw_r;
    logic               a_neg_r;
    logic               b_neg_r;
    logic               is_div_r;

    logic               is_md_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   sum_s;
    logic [WIDTH-1:0]   diff_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic               alu_ov_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_trial_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   done_hi_s;
    logic [WIDTH-1:0]   done_lo_s;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        if (neg) begin
            return {WIDTH{1'b0}} - v;
        end else begin
            return v;
        end
    endfunction

    assign is_md_s = (selectionLines[3:2] == 2'b10);
    // Opcodes with bit 0 clear (MULT, DIV) are the signed variants
    assign a_neg_s = ~selectionLines[0] & input1[WIDTH-1];
    assign b_neg_s = ~selectionLines[0] & input2[WIDTH-1];
    assign a_mag_s = magnitude(input1, a_neg_s);

    // Single-cycle result and overflow, computed from the live operands at accept
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_ov_s  = 1'b0;
        sum_s     = input1 + input2;
        diff_s    = input1 - input2;
        case (selectionLines)
            4'b0000: alu_res_s = input1 & input2;
            4'b0001: alu_res_s = input1 | input2;
            4'b0010: begin
                alu_res_s = sum_s;
                alu_ov_s  = (input1[WIDTH-1] == input2[WIDTH-1]) && (sum_s[WIDTH-1] != input1[WIDTH-1]);
            end
            4'b0011: alu_res_s = input1 ^ input2;
            4'b0110: begin
                alu_res_s = diff_s;
                alu_ov_s  = (input1[WIDTH-1] != input2[WIDTH-1]) && (diff_s[WIDTH-1] != input1[WIDTH-1]);
            end
            4'b0100: alu_res_s = {{(WIDTH-1){1'b0}}, (input1 < input2)};
            4'b0111: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
            4'b1100: alu_res_s = hi_r;
            4'b1101: alu_res_s = lo_r;
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // One shift-add / restoring-divide step, and the sign-corrected final HI/LO
    always_comb begin
        mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]} +
                      (prod_r[0] ? {1'b0, b_mag_r} : {(WIDTH+1){1'b0}});
        div_trial_s = {rem_r, quo_r[WIDTH-1]} - {1'b0, b_mag_r};
        prod_fix_s  = (a_neg_r ^ b_neg_r) ? ({(2*WIDTH){1'b0}} - prod_r) : prod_r;
        done_hi_s   = {WIDTH{1'b0}};
        done_lo_s   = {WIDTH{1'b0}};
        if (is_div_r) begin
            if (b_mag_r == {WIDTH{1'b0}}) begin
                done_lo_s = {WIDTH{1'b1}};
                done_hi_s = a_raw_r;
            end else begin
                done_lo_s = magnitude(quo_r, a_neg_r ^ b_neg_r);
                done_hi_s = magnitude(rem_r, a_neg_r);
            end
        end else begin
            done_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            done_lo_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // Control FSM, iterative datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b1;
            ovf_r       <= 1'b0;
            dbz_r       <= 1'b0;
            hi_r        <= {WIDTH{1'b0}};
            lo_r        <= {WIDTH{1'b0}};
            cnt_r       <= CNT_ZERO;
            prod_r      <= {(2*WIDTH){1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            b_mag_r     <= {WIDTH{1'b0}};
            a_raw_r     <= {WIDTH{1'b0}};
            a_neg_r     <= 1'b0;
            b_neg_r     <= 1'b0;
            is_div_r    <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        if (is_md_s) begin
                            a_raw_r    <= input1;
                            a_neg_r    <= a_neg_s;
                            b_neg_r    <= b_neg_s;
                            b_mag_r    <= magnitude(input2, b_neg_s);
                            prod_r     <= {{WIDTH{1'b0}}, a_mag_s};
                            quo_r      <= a_mag_s;
                            rem_r      <= {WIDTH{1'b0}};
                            cnt_r      <= CNT_LAST;
                            is_div_r   <= selectionLines[1];
                            in_ready_r <= 1'b0;
                            state_r    <= selectionLines[1] ? DIV : MUL;
                        end else begin
                            result_r    <= alu_res_s;
                            zero_r      <= (alu_res_s == {WIDTH{1'b0}});
                            ovf_r       <= alu_ov_s;
                            dbz_r       <= 1'b0;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    prod_r <= {mul_sum_s, prod_r[WIDTH-1:1]};
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                DIV: begin
                    if (!div_trial_s[WIDTH]) begin
                        rem_r <= div_trial_s[WIDTH-1:0];
                    end else begin
                        rem_r <= {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
                    end
                    quo_r <= {quo_r[WIDTH-2:0], ~div_trial_s[WIDTH]};
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                DONE: begin
                    hi_r        <= done_hi_s;
                    lo_r        <= done_lo_s;
                    result_r    <= done_lo_s;
                    zero_r      <= (done_lo_s == {WIDTH{1'b0}});
                    ovf_r       <= 1'b0;
                    dbz_r       <= is_div_r && (b_mag_r == {WIDTH{1'b0}});
                    out_valid_r <= 1'b1;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign ALU_result  = result_r;
    assign zero        = zero_r;
    assign overflow    = ovf_r;
    assign div_by_zero = dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule

// File: tb/tb_mips_alu_muldiv.sv
// Scoreboard bench for mips_alu_muldiv (WIDTH=32): expectations come from a
// behavioural arithmetic model and are compared whenever out_valid pulses.
module tb_mips_alu_muldiv;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  sel = 4'b0000;
    logic [31:0] in1 = 32'd0;
    logic [31:0] in2 = 32'd0;
    logic        out_valid;
    logic [31:0] alu_result;
    logic        zero, overflow, div_by_zero;
    logic [31:0] hi, lo;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;
    int          n_checks = 0;
    int          n_fail = 0;

    mips_alu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .selectionLines(sel), .input1(in1), .input2(in2), .out_valid(out_valid),
        .ALU_result(alu_result), .zero(zero), .overflow(overflow),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation time limit reached, required test completion");
        $fatal(1, "timeout");
    end

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] h, input logic [31:0] l);
        exp_t   e;
        longint s;
        logic [63:0] p;
        e = '0;
        e.hi = h;
        e.lo = l;
        s = 0;
        p = 64'd0;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0011: e.res = a ^ b;
            4'b0010: begin
                e.res = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                e.res = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0100: e.res = (a < b) ? 32'd1 : 32'd0;
            4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: begin
                p = longint'($signed(a)) * longint'($signed(b));
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            4'b1001: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            4'b1010, 4'b1011: begin
                if (b == 32'd0) begin
                    e.lo = 32'hFFFFFFFF; e.hi = a; e.dz = 1'b1;
                end else if (op == 4'b1010 && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    e.lo = 32'h80000000; e.hi = 32'd0;
                end else if (op == 4'b1010) begin
                    e.lo = $signed(a) / $signed(b); e.hi = $signed(a) % $signed(b);
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
            4'b1100: e.res = h;
            4'b1101: e.res = l;
            default: e.res = 32'd0;
        endcase
        if (op[3:2] == 2'b10) e.res = e.lo;
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Scoreboard: every out_valid pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out_valid: got out_valid=1 result=%h, required no pending op", alu_result);
            end else begin
                mon_e = sb.pop_front();
                if (alu_result !== mon_e.res) begin n_fail++; $display("FAIL result: got %h, required %h", alu_result, mon_e.res); end
                n_checks++;
                if (zero !== mon_e.z) begin n_fail++; $display("FAIL zero: got %b, required %b", zero, mon_e.z); end
                n_checks++;
                if (overflow !== mon_e.ov) begin n_fail++; $display("FAIL overflow: got %b, required %b", overflow, mon_e.ov); end
                n_checks++;
                if (div_by_zero !== mon_e.dz) begin n_fail++; $display("FAIL div_by_zero: got %b, required %b", div_by_zero, mon_e.dz); end
                n_checks++;
                if (hi !== mon_e.hi) begin n_fail++; $display("FAIL hi: got %h, required %h", hi, mon_e.hi); end
                n_checks++;
                if (lo !== mon_e.lo) begin n_fail++; $display("FAIL lo: got %h, required %h", lo, mon_e.lo); end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit expect_out);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; sel = op; in1 = a; in2 = b;
        if (expect_out) begin
            e = model(op, a, b, hi_m, lo_m);
            sb.push_back(e);
            hi_m = e.hi; lo_m = e.lo;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; in1 = $urandom; in2 = $urandom; sel = 4'($urandom_range(0, 15));
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        n_checks++; if (alu_result !== 32'd0 || zero !== 1'b1) begin n_fail++; $display("FAIL reset_result: got %h zero=%b, required 0 zero=1", alu_result, zero); end
        n_checks++; if (overflow !== 1'b0 || div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ov=%b dz=%b, required 0 0", overflow, div_by_zero); end
        n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL reset_hilo: got %h %h, required 0 0", hi, lo); end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        issue(4'b0010, 32'h7FFFFFFF, 32'd1, 1'b1);
        issue(4'b0110, 32'd5, 32'd7, 1'b1);
        n_checks++; if (out_valid !== 1'b1 || alu_result !== 32'h80000000 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL b2b_add: got v=%b %h ov=%b, required v=1 80000000 ov=1", out_valid, alu_result, overflow); end
        idle();
        n_checks++; if (out_valid !== 1'b1 || alu_result !== 32'hFFFFFFFE || overflow !== 1'b0 || zero !== 1'b0) begin
            n_fail++; $display("FAIL b2b_sub: got v=%b %h ov=%b z=%b, required v=1 fffffffe ov=0 z=0", out_valid, alu_result, overflow, zero); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_end: got out_valid=%b, required 0", out_valid); end
    endtask

    task automatic test_compare();
        issue(4'b0111, 32'hFFFFFFFF, 32'd1, 1'b1);
        issue(4'b0100, 32'hFFFFFFFF, 32'd1, 1'b1);
        n_checks++; if (alu_result !== 32'd1) begin n_fail++; $display("FAIL slt: got %h, required 1", alu_result); end
        idle();
        n_checks++; if (alu_result !== 32'd0 || zero !== 1'b1) begin n_fail++; $display("FAIL sltu: got %h zero=%b, required 0 zero=1", alu_result, zero); end
        @(negedge clk);
    endtask

    task automatic test_single_ops();
        logic [3:0]  ops [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0101, 4'b1111, 4'b0111};
        logic [31:0] as  [8] = '{32'hF0F0A5A5, 32'h12340000, 32'hFFFF0000, 32'h80000000, 32'h80000000, 32'h1234, 32'hFFFFFFFF, 32'd3};
        logic [31:0] bs  [8] = '{32'h0FF0FFFF, 32'h00005678, 32'hFF00FF00, 32'hFFFFFFFF, 32'd1, 32'h5678, 32'hFFFFFFFF, 32'hFFFFFFFE};
        for (int i = 0; i < 8; i++) issue(ops[i], as[i], bs[i], 1'b1);
        idle();
        @(negedge clk);
    endtask

    task automatic test_mult_mfhi();
        int cycles = 0;
        int low_cnt = 0;
        exp_t e;
        issue(4'b1000, 32'hFFFFFFFD, 32'd7, 1'b1);
        @(negedge clk);
        // Hold an MFHI request through the stall; it may only be taken after DONE
        sel = 4'b1100; in1 = 32'd0; in2 = 32'd0;
        e = model(4'b1100, 32'd0, 32'd0, hi_m, lo_m);
        sb.push_back(e);
        while (out_valid !== 1'b1 && cycles < 100) begin
            if (in_ready === 1'b0) low_cnt++;
            @(negedge clk);
            cycles++;
        end
        n_checks++; if (cycles != 33) begin n_fail++; $display("FAIL mult_latency: got %0d cycles, required 33", cycles); end
        n_checks++; if (low_cnt != 33) begin n_fail++; $display("FAIL mult_ready_low: got %0d cycles, required 33", low_cnt); end
        n_checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_hilo: got %h %h, required ffffffff ffffffeb", hi, lo); end
        idle();
        n_checks++; if (out_valid !== 1'b1 || alu_result !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mfhi: got v=%b %h, required v=1 ffffffff", out_valid, alu_result); end
        @(negedge clk);
    endtask

    task automatic test_muldiv();
        logic [3:0]  ops [9] = '{4'b1010, 4'b1011, 4'b1010, 4'b1001, 4'b1011, 4'b1010, 4'b1010, 4'b1000, 4'b1101};
        logic [31:0] as  [9] = '{32'hFFFFFFF9, 32'd9, 32'h80000000, 32'hFFFFFFFF, 32'd100, 32'd7, 32'hFFFFFFFB, 32'h80000000, 32'd0};
        logic [31:0] bs  [9] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFE, 32'd0, 32'h80000000, 32'd0};
        int cycles;
        for (int i = 0; i < 9; i++) begin
            issue(ops[i], as[i], bs[i], 1'b1);
            idle();
            cycles = 0;
            while (out_valid !== 1'b1 && cycles < 100) begin
                @(negedge clk);
                cycles++;
            end
            n_checks++;
            if (cycles != ((ops[i][3:2] == 2'b10) ? 33 : 0)) begin
                n_fail++; $display("FAIL muldiv_latency[%0d]: got %0d cycles, required %0d", i, cycles, (ops[i][3:2] == 2'b10) ? 33 : 0);
            end
            if (i == 0) begin
                n_checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_neg7_2: got lo=%h hi=%h, required fffffffd ffffffff", lo, hi); end
            end
            if (i == 1) begin
                n_checks++; if (lo !== 32'hFFFFFFFF || hi !== 32'd9 || div_by_zero !== 1'b1) begin n_fail++; $display("FAIL divu_by_zero: got lo=%h hi=%h dz=%b, required ffffffff 9 1", lo, hi, div_by_zero); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        issue(4'b1001, 32'h12345678, 32'h9ABCDEF0, 1'b0);
        idle();
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl: got rdy=%b v=%b, required 1 0", in_ready, out_valid); end
        n_checks++; if (hi !== 32'd0 || lo !== 32'd0 || zero !== 1'b1) begin n_fail++; $display("FAIL midreset_state: got hi=%h lo=%h z=%b, required 0 0 1", hi, lo, zero); end
        repeat (40) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midreset_no_output: got %0d pulses, required 0", seen); end
        issue(4'b0000, 32'h000000F0, 32'h0000003C, 1'b1);
        idle();
        n_checks++; if (out_valid !== 1'b1 || alu_result !== 32'h30) begin n_fail++; $display("FAIL midreset_and: got v=%b %h, required v=1 30", out_valid, alu_result); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_compare();
        test_single_ops();
        test_mult_mfhi();
        test_muldiv();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
